// File: rtl/lb_reg_responder.sv
// lb_reg_responder: local-bus target with RW config regs, RO status, trigger and counters
module lb_reg_responder #(
  parameter int AW = 24,
  parameter int DW = 32,
  parameter int N_REGS = 16,
  parameter logic [AW-1:0] BASE = 'h010000,
  parameter int READ_LAT = 3,
  parameter logic [DW-1:0] REG_INIT = '0
) (
  input  logic                 lb_clk,
  input  logic                 lb_rstn,
  input  logic [AW-1:0]        lb_addr,
  input  logic [DW-1:0]        lb_data,
  input  logic                 lb_strobe,
  input  logic                 lb_rd,
  input  logic                 lb_write,
  output logic [DW-1:0]        lb_din,
  output logic                 lb_hit,
  input  logic [N_REGS*DW-1:0] status_in,
  output logic [N_REGS*DW-1:0] cfg_regs,
  output logic [N_REGS-1:0]    cfg_wstb,
  output logic [DW-1:0]        trig_pulse
);
  localparam int LW = $clog2(N_REGS);
  localparam int SEL_W = LW + 2;
  logic [DW-1:0] cfg [N_REGS];
  logic [DW-1:0] sts [N_REGS];
  logic [DW-1:0] pd [READ_LAT];
  logic [READ_LAT-1:0] ph;
  logic [15:0] txn_cnt, err_cnt;
  logic [LW-1:0] idx;
  logic [1:0] qd;
  logic in_win, rd_hit, wr_hit, is_trig, is_cnt;
  logic [DW-1:0] rd_word;
  assign idx = lb_addr[LW-1:0];
  assign qd = lb_addr[SEL_W-1:LW];
  assign in_win = lb_addr[AW-1:SEL_W] == BASE[AW-1:SEL_W];
  assign rd_hit = lb_strobe & lb_rd & in_win;
  assign wr_hit = lb_strobe & lb_write & ~lb_rd & in_win;
  assign is_trig = qd == 2'd2 && idx == LW'(0);
  assign is_cnt = qd == 2'd2 && idx == LW'(1);
  assign lb_din = pd[READ_LAT-1];
  assign lb_hit = ph[READ_LAT-1];
  genvar g;
  for (g = 0; g < N_REGS; g++) begin : g_w
    assign sts[g] = status_in[g*DW +: DW];
    assign cfg_regs[g*DW +: DW] = cfg[g];
  end
  always_comb
    rd_word = qd == 2'd0 ? cfg[idx] : qd == 2'd1 ? sts[idx] : is_cnt ? DW'({err_cnt, txn_cnt}) : '0;
  always_ff @(posedge lb_clk) begin
    if (!lb_rstn) begin
      for (int i = 0; i < N_REGS; i++) cfg[i] <= REG_INIT;
      for (int i = 0; i < READ_LAT; i++) pd[i] <= '0;
      ph <= '0;
      cfg_wstb <= '0;
      trig_pulse <= '0;
      txn_cnt <= '0;
      err_cnt <= '0;
    end else begin
      cfg_wstb <= '0;
      if (wr_hit && qd == 2'd0) begin
        cfg[idx] <= lb_data;
        cfg_wstb[idx] <= 1'b1;
      end
      trig_pulse <= wr_hit && is_trig ? lb_data : '0;
      if (wr_hit && is_cnt) begin
        txn_cnt <= '0;
        err_cnt <= '0;
      end else begin
        if (rd_hit || wr_hit) txn_cnt <= txn_cnt + 16'd1;
        if (rd_hit && lb_write && err_cnt != 16'hFFFF) err_cnt <= err_cnt + 16'd1;
      end
      ph[0] <= rd_hit;
      pd[0] <= rd_hit ? rd_word : '0;
      for (int i = 1; i < READ_LAT; i++) begin
        ph[i] <= ph[i-1];
        pd[i] <= pd[i-1];
      end
    end
  end
endmodule

// File: tb/tb_lb_reg_responder.sv
// tb_lb_reg_responder: directed stimulus with a read-response scoreboard
module tb_lb_reg_responder;
  logic clk = 0;
  always #5 clk = ~clk;
  logic rstn, strobe, rd, wr, hit;
  logic [23:0] addr;
  logic [31:0] data, din, trig;
  logic [511:0] status, cfg;
  logic [15:0] wstb;
  typedef struct {int c; logic h; logic [31:0] d;} exp_t;
  exp_t q[$];
  exp_t e;
  int n_cmp = 0, n_bad = 0, cyc = 0;
  bit mon_en = 0;
  lb_reg_responder dut (
    .lb_clk(clk), .lb_rstn(rstn), .lb_addr(addr), .lb_data(data), .lb_strobe(strobe),
    .lb_rd(rd), .lb_write(wr), .lb_din(din), .lb_hit(hit), .status_in(status),
    .cfg_regs(cfg), .cfg_wstb(wstb), .trig_pulse(trig)
  );
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    n_cmp++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", nm, act, want, cyc);
    end
  endtask
  always @(negedge clk) begin
    if (mon_en) begin
      if (q.size() > 0 && q[0].c <= cyc) begin
        e = q.pop_front();
        if (e.c != cyc) begin
          n_cmp++;
          n_bad++;
          $display("FAIL rd_slot: response due %0d checked at %0d", e.c, cyc);
        end else begin
          chk("rd_hit", 32'(hit), 32'(e.h));
          chk("rd_din", din, e.d);
        end
      end else begin
        chk("idle_hit", 32'(hit), 0);
        chk("idle_din", din, 0);
      end
    end
  end
  task automatic txn(input logic [23:0] a, input logic [31:0] d, input logic r, input logic w,
                     input logic push, input logic eh, input logic [31:0] ed);
    @(posedge clk); #1;
    addr = a; data = d; rd = r; wr = w; strobe = 1;
    if (r && push) q.push_back('{cyc + 3, eh, ed});
  endtask
  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      strobe = 0; rd = 0; wr = 0;
    end
  endtask
  initial begin
    rstn = 0; strobe = 0; rd = 0; wr = 0; addr = '0; data = '0;
    status = '0;
    status[0 +: 32] = 32'h1111_0000;
    status[5*32 +: 32] = 32'hCAFE_0005;
    repeat (3) @(posedge clk);
    #1 rstn = 1; mon_en = 1;
    chk("rst_cfg_nonzero", 32'(cfg !== '0), 0);
    chk("rst_wstb", 32'(wstb), 0);
    chk("rst_trig", trig, 0);
    txn(24'h010000, 0, 1, 0, 1, 1, 32'h0);
    idle(2);
    txn(24'h010003, 32'hA5A5_1234, 0, 1, 0, 0, 0);
    txn(24'h010003, 0, 1, 0, 1, 1, 32'hA5A5_1234);
    chk("wstb_pulse", 32'(wstb), 32'h0008);
    chk("cfg_w3", cfg[3*32 +: 32], 32'hA5A5_1234);
    idle(1);
    chk("wstb_clear", 32'(wstb), 0);
    txn(24'h010015, 0, 1, 0, 1, 1, 32'hCAFE_0005);
    idle(1);
    txn(24'h010020, 32'h0000_0081, 0, 1, 0, 0, 0);
    idle(1);
    chk("trig_pulse", trig, 32'h81);
    idle(1);
    chk("trig_clear", trig, 0);
    txn(24'h010020, 0, 1, 0, 1, 1, 32'h0);
    txn(24'h01003C, 0, 1, 0, 1, 1, 32'h0);
    txn(24'h010021, 32'hFFFF_FFFF, 0, 1, 0, 0, 0);
    txn(24'h010003, 0, 1, 0, 1, 1, 32'hA5A5_1234);
    txn(24'h010015, 0, 1, 0, 1, 1, 32'hCAFE_0005);
    txn(24'h010000, 0, 1, 0, 1, 1, 32'h0);
    txn(24'h010010, 0, 1, 0, 1, 1, 32'h1111_0000);
    txn(24'h010003, 32'hDEAD_BEEF, 1, 1, 1, 1, 32'hA5A5_1234);
    txn(24'h010021, 0, 1, 0, 1, 1, 32'h0001_0005);
    idle(1);
    chk("collision_no_write", cfg[3*32 +: 32], 32'hA5A5_1234);
    chk("collision_no_wstb", 32'(wstb), 0);
    txn(24'h010021, 0, 0, 1, 0, 0, 0);
    txn(24'h010021, 0, 1, 0, 1, 1, 32'h0);
    txn(24'h020000, 0, 1, 0, 1, 0, 32'h0);
    txn(24'h020003, 32'h1234_5678, 0, 1, 0, 0, 0);
    idle(1);
    chk("oow_no_write", cfg[3*32 +: 32], 32'hA5A5_1234);
    chk("oow_no_wstb", 32'(wstb), 0);
    txn(24'h010021, 0, 1, 0, 1, 1, 32'h0000_0001);
    idle(4);
    txn(24'h010003, 0, 1, 0, 1, 1, 32'hA5A5_1234);
    txn(24'h010015, 0, 1, 0, 0, 0, 0);
    txn(24'h010000, 0, 1, 0, 0, 0, 0);
    @(posedge clk); #1;
    strobe = 0; rd = 0; rstn = 0;
    @(posedge clk); #1;
    rstn = 1;
    chk("rst2_cfg_nonzero", 32'(cfg !== '0), 0);
    chk("rst2_hit", 32'(hit), 0);
    idle(2);
    txn(24'h010021, 0, 1, 0, 1, 1, 32'h0);
    idle(8);
    chk("sb_empty", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
